control_unit: RTL and testbench

Multi-cycle control FSM for the K&S processor core. It receives the decoded instruction and the registered ALU flags from `data_path`, and drives all of the datapath's sequencing controls plus the RAM write strobe. One instruction executes at a time over 2–4 cycles. A HALT instruction parks the core until reset.

---
 rtl/k_and_s_pkg.sv | 107 ++++++++++
 rtl/control_unit.sv | 160 ++++++++++++++++
 tb/tb_control_unit.sv | 219 +++++++++++++++++++++
 3 files changed

// File: rtl/k_and_s_pkg.sv
// Shared types and constants for the K&S processor core: instruction decode
// values coming out of data_path, the control FSM state set, ALU operation
// codes, and small decode helpers used by the control unit.
package k_and_s_pkg;

  // Instruction decode produced by data_path from the instruction register.
  // Encodings 16..31 are unused and are treated as NOP by the control unit.
  typedef enum logic [4:0] {
    I_NOP    = 5'd0,
    I_LOAD   = 5'd1,
    I_STORE  = 5'd2,
    I_MOVE   = 5'd3,
    I_ADD    = 5'd4,
    I_SUB    = 5'd5,
    I_AND    = 5'd6,
    I_OR     = 5'd7,
    I_BRANCH = 5'd8,
    I_BZERO  = 5'd9,
    I_BNZERO = 5'd10,
    I_BNEG   = 5'd11,
    I_BNNEG  = 5'd12,
    I_BOV    = 5'd13,
    I_BNOV   = 5'd14,
    I_HALT   = 5'd15
  } decoded_instruction_type;

  // Control FSM states.
  typedef enum logic [2:0] {
    S_FETCH     = 3'd0,
    S_DECODE    = 3'd1,
    S_EXEC_ALU  = 3'd2,
    S_LOAD_ADDR = 3'd3,
    S_LOAD_WB   = 3'd4,
    S_STORE     = 3'd5,
    S_BRANCH    = 3'd6,
    S_HALT      = 3'd7
  } ctrl_state_type;

  // ALU operation select driven onto data_path.
  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_AND = 2'b01;
  localparam logic [1:0] ALU_OR  = 2'b10;
  localparam logic [1:0] ALU_SUB = 2'b11;

  // True for instructions that write back an ALU result.
  function automatic logic is_alu_instr(input decoded_instruction_type instr);
    logic result;
    case (instr)
      I_ADD, I_SUB, I_AND, I_OR, I_MOVE: result = 1'b1;
      default:                           result = 1'b0;
    endcase
    return result;
  endfunction

  // True for the six flag-dependent branches.
  function automatic logic is_cond_branch(input decoded_instruction_type instr);
    logic result;
    case (instr)
      I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: result = 1'b1;
      default:                                           result = 1'b0;
    endcase
    return result;
  endfunction

  // Evaluate a conditional branch against the registered flags.
  function automatic logic cond_holds(input decoded_instruction_type instr,
                                      input logic zero_f,
                                      input logic neg_f,
                                      input logic sovf_f);
    logic result;
    case (instr)
      I_BZERO:  result = zero_f;
      I_BNZERO: result = ~zero_f;
      I_BNEG:   result = neg_f;
      I_BNNEG:  result = ~neg_f;
      I_BOV:    result = sovf_f;
      I_BNOV:   result = ~sovf_f;
      default:  result = 1'b0;
    endcase
    return result;
  endfunction

  // ALU op for the execute cycle. MOVE is an OR of a register with itself.
  function automatic logic [1:0] alu_op_for(input decoded_instruction_type instr);
    logic [1:0] result;
    case (instr)
      I_ADD:   result = ALU_ADD;
      I_AND:   result = ALU_AND;
      I_OR:    result = ALU_OR;
      I_SUB:   result = ALU_SUB;
      I_MOVE:  result = ALU_OR;
      default: result = ALU_ADD;
    endcase
    return result;
  endfunction

  // Arithmetic/logic ops update the flags; MOVE leaves them untouched.
  function automatic logic alu_sets_flags(input decoded_instruction_type instr);
    logic result;
    case (instr)
      I_ADD, I_SUB, I_AND, I_OR: result = 1'b1;
      default:                   result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/control_unit.sv
// Multi-cycle control FSM for the K&S core. Sequences one instruction at a
// time (2-4 cycles) and drives the data_path strobes plus the RAM write
// enable. Outputs are decoded from the state register; the ALU op and
// flag-write choice for EXEC_ALU are captured in DECODE so that the execute
// cycle stays a pure function of registered state. A synchronous reset
// forces every output low in the cycle it is asserted, so an interrupted
// instruction performs no write and does not retire.
module control_unit
  import k_and_s_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  decoded_instruction_type decoded_instruction,
  input  logic                    zero_op,
  input  logic                    neg_op,
  input  logic                    unsigned_overflow,
  input  logic                    signed_overflow,
  output logic                    branch,
  output logic                    pc_enable,
  output logic                    ir_enable,
  output logic                    addr_sel,
  output logic                    c_sel,
  output logic [1:0]              operation,
  output logic                    write_reg_enable,
  output logic                    flags_reg_enable,
  output logic                    ram_write_enable,
  output logic                    halt,
  output logic                    instr_retired
);

  ctrl_state_type state_q, state_d;
  logic [1:0]     alu_op_q, alu_op_d;
  logic           alu_flags_q, alu_flags_d;

  // The carry flag has no branch condition in this instruction set.
  logic unused_carry_s;
  assign unused_carry_s = unsigned_overflow;

  // State register plus the execute-cycle ALU controls captured in DECODE.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_FETCH;
      alu_op_q    <= ALU_ADD;
      alu_flags_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_op_q    <= alu_op_d;
      alu_flags_q <= alu_flags_d;
    end
  end

  // Next-state selection and per-state output decode.
  always_comb begin
    state_d          = state_q;
    alu_op_d         = alu_op_q;
    alu_flags_d      = alu_flags_q;
    branch           = 1'b0;
    pc_enable        = 1'b0;
    ir_enable        = 1'b0;
    addr_sel         = 1'b0;
    c_sel            = 1'b0;
    operation        = ALU_ADD;
    write_reg_enable = 1'b0;
    flags_reg_enable = 1'b0;
    ram_write_enable = 1'b0;
    halt             = 1'b0;
    instr_retired    = 1'b0;

    if (rst) begin
      // All strobes held low; the register reloads FETCH on this edge.
      state_d = S_FETCH;
    end else begin
      case (state_q)
        S_FETCH: begin
          addr_sel  = 1'b0;
          ir_enable = 1'b1;
          state_d   = S_DECODE;
        end

        S_DECODE: begin
          pc_enable   = 1'b1;
          branch      = 1'b0;
          alu_op_d    = alu_op_for(decoded_instruction);
          alu_flags_d = alu_sets_flags(decoded_instruction);
          if (is_alu_instr(decoded_instruction)) begin
            state_d = S_EXEC_ALU;
          end else if (decoded_instruction == I_LOAD) begin
            state_d = S_LOAD_ADDR;
          end else if (decoded_instruction == I_STORE) begin
            state_d = S_STORE;
          end else if (decoded_instruction == I_BRANCH) begin
            state_d = S_BRANCH;
          end else if (is_cond_branch(decoded_instruction)) begin
            if (cond_holds(decoded_instruction, zero_op, neg_op, signed_overflow)) begin
              state_d = S_BRANCH;
            end else begin
              // Not-taken branch completes here.
              state_d       = S_FETCH;
              instr_retired = 1'b1;
            end
          end else if (decoded_instruction == I_HALT) begin
            state_d = S_HALT;
          end else begin
            // NOP and unused encodings complete here.
            state_d       = S_FETCH;
            instr_retired = 1'b1;
          end
        end

        S_EXEC_ALU: begin
          c_sel            = 1'b0;
          write_reg_enable = 1'b1;
          operation        = alu_op_q;
          flags_reg_enable = alu_flags_q;
          instr_retired    = 1'b1;
          state_d          = S_FETCH;
        end

        S_LOAD_ADDR: begin
          // Memory read-latency cycle with the operand address applied.
          addr_sel = 1'b1;
          state_d  = S_LOAD_WB;
        end

        S_LOAD_WB: begin
          addr_sel         = 1'b1;
          c_sel            = 1'b1;
          write_reg_enable = 1'b1;
          instr_retired    = 1'b1;
          state_d          = S_FETCH;
        end

        S_STORE: begin
          addr_sel         = 1'b1;
          ram_write_enable = 1'b1;
          instr_retired    = 1'b1;
          state_d          = S_FETCH;
        end

        S_BRANCH: begin
          pc_enable     = 1'b1;
          branch        = 1'b1;
          instr_retired = 1'b1;
          state_d       = S_FETCH;
        end

        S_HALT: begin
          // Parked until reset.
          halt    = 1'b1;
          state_d = S_HALT;
        end

        default: begin
          state_d = S_FETCH;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_control_unit.sv
// Self-checking bench for control_unit. For each instruction the reference
// model writes down the expected per-cycle control vector straight from the
// instruction's behaviour (fetch, decode, then the instruction's own cycles),
// and the bench compares the DUT outputs against it every cycle.
module tb_control_unit;
  import k_and_s_pkg::*;

  logic clk = 1'b0;
  logic rst;
  decoded_instruction_type di;
  logic zf, nf, cf, vf;
  logic branch, pc_enable, ir_enable, addr_sel, c_sel;
  logic [1:0] operation;
  logic write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_retired;

  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  always #5 clk = ~clk;

  control_unit dut (
    .clk                 (clk),
    .rst                 (rst),
    .decoded_instruction (di),
    .zero_op             (zf),
    .neg_op              (nf),
    .unsigned_overflow   (cf),
    .signed_overflow     (vf),
    .branch              (branch),
    .pc_enable           (pc_enable),
    .ir_enable           (ir_enable),
    .addr_sel            (addr_sel),
    .c_sel               (c_sel),
    .operation           (operation),
    .write_reg_enable    (write_reg_enable),
    .flags_reg_enable    (flags_reg_enable),
    .ram_write_enable    (ram_write_enable),
    .halt                (halt),
    .instr_retired       (instr_retired)
  );

  logic [11:0] obs;
  assign obs = {branch, pc_enable, ir_enable, addr_sel, c_sel, operation,
                write_reg_enable, flags_reg_enable, ram_write_enable, halt, instr_retired};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h", tag, got, exp);
    end
  endtask

  // Control vector {branch,pc_en,ir_en,addr_sel,c_sel,op,wr,fl,ramwr,halt,retired}.
  function automatic logic [11:0] mk(input logic br, input logic pc, input logic ir,
                                     input logic as, input logic cs, input logic [1:0] op,
                                     input logic wr, input logic fl, input logic rw,
                                     input logic h, input logic ret);
    return {br, pc, ir, as, cs, op, wr, fl, rw, h, ret};
  endfunction

  // Reference: expected per-cycle controls for one instruction.
  task automatic build_expected(input decoded_instruction_type ins,
                                input logic z, input logic n, input logic v);
    logic [11:0] f_v, d_v, d_ret_v;
    logic taken;
    f_v     = mk(1'b0,1'b0,1'b1,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0);
    d_v     = mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0);
    d_ret_v = mk(1'b0,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1);
    exp_q.delete();
    exp_q.push_back(f_v);
    taken = 1'b0;
    if (ins == I_BRANCH) taken = 1'b1;
    if (ins == I_BZERO)  taken = z;
    if (ins == I_BNZERO) taken = !z;
    if (ins == I_BNEG)   taken = n;
    if (ins == I_BNNEG)  taken = !n;
    if (ins == I_BOV)    taken = v;
    if (ins == I_BNOV)   taken = !v;
    case (ins)
      I_ADD:  begin exp_q.push_back(d_v); exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b00,1'b1,1'b1,1'b0,1'b0,1'b1)); end
      I_AND:  begin exp_q.push_back(d_v); exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b01,1'b1,1'b1,1'b0,1'b0,1'b1)); end
      I_OR:   begin exp_q.push_back(d_v); exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,1'b1,1'b0,1'b0,1'b1)); end
      I_SUB:  begin exp_q.push_back(d_v); exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b11,1'b1,1'b1,1'b0,1'b0,1'b1)); end
      I_MOVE: begin exp_q.push_back(d_v); exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'b10,1'b1,1'b0,1'b0,1'b0,1'b1)); end
      I_LOAD: begin
        exp_q.push_back(d_v);
        exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b0));
        exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b1,2'd0,1'b1,1'b0,1'b0,1'b0,1'b1));
      end
      I_STORE: begin
        exp_q.push_back(d_v);
        exp_q.push_back(mk(1'b0,1'b0,1'b0,1'b1,1'b0,2'd0,1'b0,1'b0,1'b1,1'b0,1'b1));
      end
      I_BRANCH, I_BZERO, I_BNZERO, I_BNEG, I_BNNEG, I_BOV, I_BNOV: begin
        if (taken) begin
          exp_q.push_back(d_v);
          exp_q.push_back(mk(1'b1,1'b1,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b0,1'b1));
        end else begin
          exp_q.push_back(d_ret_v);
        end
      end
      I_HALT:  exp_q.push_back(d_v);
      default: exp_q.push_back(d_ret_v);
    endcase
  endtask

  // Run one instruction from FETCH; optionally assert rst during cycle abort_at.
  // Entered and left at 1 time unit after a rising edge with the DUT in FETCH
  // (or in HALT when the instruction is I_HALT).
  task automatic run_instr(input decoded_instruction_type ins, input logic z,
                           input logic n, input logic v, input int abort_at);
    int len;
    build_expected(ins, z, n, v);
    len = exp_q.size();
    di = ins;
    zf = z;
    nf = n;
    vf = v;
    for (int k = 0; k < len; k++) begin
      cf = 1'($urandom_range(0, 1));
      if (k == abort_at) rst = 1'b1;
      #1;
      if (k == abort_at)
        check($sformatf("abort_%0d_c%0d", ins, k), {20'd0, obs}, 32'd0);
      else
        check($sformatf("ins_%0d_c%0d", ins, k), {20'd0, obs}, {20'd0, exp_q[k]});
      @(posedge clk);
      #1;
      if (k == abort_at) begin
        rst = 1'b0;
        break;
      end
    end
  endtask

  // Hold rst for the given number of cycles, checking outputs stay low.
  task automatic reset_pulse(input int cycles, input string tag);
    rst = 1'b1;
    for (int k = 0; k < cycles; k++) begin
      #1;
      check($sformatf("%s_%0d", tag, k), {20'd0, obs}, 32'd0);
      @(posedge clk);
      #1;
    end
    rst = 1'b0;
  endtask

  initial begin
    logic [4:0] code;
    rst = 1'b1;
    di  = I_NOP;
    zf  = 1'b0;
    nf  = 1'b0;
    cf  = 1'b0;
    vf  = 1'b0;
    @(posedge clk);
    #1;
    reset_pulse(2, "rst_init");

    // Directed: main instruction classes.
    run_instr(I_ADD,   1'b0, 1'b0, 1'b0, -1);
    run_instr(I_MOVE,  1'b1, 1'b0, 1'b1, -1);
    run_instr(I_SUB,   1'b0, 1'b1, 1'b0, -1);
    run_instr(I_AND,   1'b0, 1'b0, 1'b0, -1);
    run_instr(I_OR,    1'b0, 1'b0, 1'b0, -1);
    run_instr(I_LOAD,  1'b0, 1'b0, 1'b0, -1);
    run_instr(I_STORE, 1'b0, 1'b0, 1'b0, -1);
    run_instr(I_BRANCH,1'b0, 1'b0, 1'b0, -1);
    run_instr(I_NOP,   1'b0, 1'b0, 1'b0, -1);
    di = decoded_instruction_type'(5'd23);
    run_instr(di,      1'b0, 1'b0, 1'b0, -1);

    // All six conditional branches, both flag polarities.
    for (int f = 0; f < 2; f++)
      for (int i = 9; i <= 14; i++)
        run_instr(decoded_instruction_type'(5'(i)), 1'(f), 1'(f), 1'(f), -1);

    // Reset in the middle of instructions: no write, no retire, FETCH follows.
    run_instr(I_ADD,   1'b0, 1'b0, 1'b0, 2);
    run_instr(I_STORE, 1'b0, 1'b0, 1'b0, 2);
    run_instr(I_LOAD,  1'b0, 1'b0, 1'b0, 3);
    run_instr(I_BZERO, 1'b1, 1'b0, 1'b0, 2);
    run_instr(I_NOP,   1'b0, 1'b0, 1'b0, -1);

    // Randomized instruction stream; HALT slot replaced by an unused code.
    for (int t = 0; t < 400; t++) begin
      code = 5'($urandom_range(0, 16));
      if (code == 5'd15) code = 5'd16 + 5'($urandom_range(0, 15));
      run_instr(decoded_instruction_type'(code),
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), -1);
    end

    // HALT parks the core with every strobe low until reset.
    run_instr(I_HALT, 1'b0, 1'b0, 1'b0, -1);
    for (int k = 0; k < 20; k++) begin
      di = decoded_instruction_type'(5'($urandom_range(0, 15)));
      zf = 1'($urandom_range(0, 1));
      #1;
      check($sformatf("halt_%0d", k), {20'd0, obs},
            {20'd0, mk(1'b0,1'b0,1'b0,1'b0,1'b0,2'd0,1'b0,1'b0,1'b0,1'b1,1'b0)});
      @(posedge clk);
      #1;
    end
    reset_pulse(2, "rst_halt");
    run_instr(I_STORE, 1'b0, 1'b0, 1'b0, -1);

    // Reset while halted at a single cycle also returns to FETCH.
    run_instr(I_HALT, 1'b0, 1'b0, 1'b0, -1);
    reset_pulse(1, "rst_halt1");
    run_instr(I_ADD, 1'b0, 1'b0, 1'b0, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
